// File: rtl/bias_act_stage.sv
// Bias-add plus ReLU stage for one systolic column lane: 2-stage valid/ready pipeline, Q8.8 data.
// Define BIAS_ACT_LEAKY_EN to scale negative sums by leak_factor instead of zeroing them.
module bias_act_stage #(
   parameter int unsigned NUM_COLS = 4,
   parameter int unsigned IDX_W    = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [15:0]      in_data,
   output logic             in_ready,
   input  logic             bias_wr_en,
   input  logic [IDX_W-1:0] bias_wr_addr,
   input  logic [15:0]      bias_wr_data,
   input  logic [15:0]      leak_factor,
   input  logic             idx_clear,
   output logic             out_valid,
   output logic [15:0]      out_data,
   input  logic             out_ready,
   output logic             sat_flag
);

   logic             s1_valid_q, s2_valid_q;
   logic [15:0]      s1_data_q, s2_data_q;
   logic [IDX_W-1:0] idx_q, idx_d, idx_use;
   logic [15:0]      bias_q [NUM_COLS];
   logic             sat_q, sat_d;
   logic             s1_adv, s2_adv, accept;
   logic [16:0]      sum17;
   logic             sum_ovf;
   logic [15:0]      sum_sat;
   logic [15:0]      act;

   assign s2_adv   = !s2_valid_q || out_ready;
   assign s1_adv   = !s1_valid_q || s2_adv;
   assign in_ready = s1_adv;
   assign accept   = in_valid && s1_adv;
   assign idx_use  = idx_clear ? '0 : idx_q;

   // 17-bit sum; a mismatch between the top two bits means it does not fit in 16.
   always_comb begin
      sum17   = {in_data[15], in_data} + {bias_q[idx_use][15], bias_q[idx_use]};
      sum_ovf = sum17[16] ^ sum17[15];
      sum_sat = sum17[15:0];
      if (sum_ovf) begin
         sum_sat = sum17[16] ? 16'h8000 : 16'h7FFF;
      end
   end

   always_comb begin
      idx_d = idx_use;
      if (accept) begin
         idx_d = (idx_use == IDX_W'(NUM_COLS - 1)) ? '0 : idx_use + 1'b1;
      end
      // A saturation in the same cycle as idx_clear keeps the flag set.
      sat_d = (accept && sum_ovf) || (sat_q && !idx_clear);
   end

`ifdef BIAS_ACT_LEAKY_EN
   logic signed [15:0] s1_s, leak_s;
   logic signed [31:0] prod, prod_sh;

   assign s1_s   = s1_data_q;
   assign leak_s = leak_factor;

   always_comb begin
      prod    = s1_s * leak_s;
      prod_sh = prod >>> 8;
      act     = s1_data_q;
      if (s1_data_q[15]) begin
         if (prod_sh > 32'sd32767) begin
            act = 16'h7FFF;
         end else if (prod_sh < -32'sd32768) begin
            act = 16'h8000;
         end else begin
            act = prod_sh[15:0];
         end
      end
   end
`else
   logic unused_leak;
   assign unused_leak = ^leak_factor;

   always_comb begin
      act = s1_data_q[15] ? 16'h0000 : s1_data_q;
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s1_data_q  <= 16'h0000;
         s2_data_q  <= 16'h0000;
         idx_q      <= '0;
         sat_q      <= 1'b0;
      end else begin
         if (s1_adv) begin
            s1_valid_q <= accept;
            if (accept) begin
               s1_data_q <= sum_sat;
            end
         end
         if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
               s2_data_q <= act;
            end
         end
         idx_q <= idx_d;
         sat_q <= sat_d;
      end
   end

   // Written after the S1 read, so a same-cycle write to the indexed entry is seen next time.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_COLS; i++) begin
            bias_q[i] <= 16'h0000;
         end
      end else if (bias_wr_en && (32'(bias_wr_addr) < NUM_COLS)) begin
         bias_q[bias_wr_addr] <= bias_wr_data;
      end
   end

   assign out_valid = s2_valid_q;
   assign out_data  = s2_data_q;
   assign sat_flag  = sat_q;

endmodule
